// File: rtl/pixel_stream_buffer.sv
`default_nettype none
// ============================================================================
// Module   : pixel_stream_buffer
// Purpose  : Banked frame store with random-access pixel writes and a raster
//            valid/ready output stream with optional horizontal blanking.
// Revision : 1.0
// ============================================================================
module pixel_stream_buffer #(
    parameter int CH_W       = 32,
    parameter int NUM_CH     = 3,
    parameter int IMG_W      = 1448,
    parameter int IMG_H      = 1072,
    parameter int BANK_ROWS  = 67,
    parameter int HBLANK     = 0,
    parameter int CONTINUOUS = 0
) (
    input  logic                     clk50,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [11:0]              wr_row,
    input  logic [11:0]              wr_col,
    input  logic [NUM_CH*CH_W-1:0]   wr_data,
    output logic                     wr_err,
    input  logic                     start,
    output logic                     busy,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [NUM_CH*CH_W-1:0]   m_data,
    output logic                     m_sof,
    output logic                     m_eol,
    output logic                     m_eof,
    output logic [11:0]              pixel_row,
    output logic [11:0]              pixel_col
);

    localparam int c_PIX_W     = NUM_CH * CH_W;
    localparam int c_NUM_BANKS = (IMG_H + BANK_ROWS - 1) / BANK_ROWS;
    localparam int c_BW        = (c_NUM_BANKS > 1) ? $clog2(c_NUM_BANKS) : 1;
    localparam int c_LW        = (BANK_ROWS > 1) ? $clog2(BANK_ROWS) : 1;
    localparam int c_CW        = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam logic [11:0] c_LAST_COL   = 12'(IMG_W - 1);
    localparam logic [11:0] c_LAST_ROW   = 12'(IMG_H - 1);
    localparam logic [15:0] c_BLANK_LAST = 16'((HBLANK > 0) ? HBLANK - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_BLANK  = 2'd2
    } state_t;

    function automatic logic [c_BW-1:0] f_bank(input logic [11:0] row);
        return c_BW'(row / 12'(BANK_ROWS));
    endfunction

    function automatic logic [c_LW-1:0] f_lrow(input logic [11:0] row);
        return c_LW'(row % 12'(BANK_ROWS));
    endfunction

    logic [c_PIX_W-1:0] r_mem [c_NUM_BANKS][BANK_ROWS][IMG_W];

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_valid;
    logic               w_valid_nxt;
    logic [11:0]        r_row;
    logic [11:0]        r_col;
    logic [11:0]        w_row_nxt;
    logic [11:0]        w_col_nxt;
    logic [15:0]        r_blank_cnt;
    logic [15:0]        w_blank_cnt_nxt;
    logic               w_ld;
    logic [c_PIX_W-1:0] r_data;
    logic [c_PIX_W-1:0] w_rd_data;
    logic               r_wr_err;
    logic               w_wr_ok;
    logic               w_xfer;
    logic               w_at_eol;
    logic               w_at_eof;

    assign w_wr_ok  = wr_en && (wr_row < 12'(IMG_H)) && (wr_col < 12'(IMG_W));
    assign w_xfer   = r_valid && m_ready;
    assign w_at_eol = (r_col == c_LAST_COL);
    assign w_at_eof = w_at_eol && (r_row == c_LAST_ROW);

    // Memory is not reset so frame contents survive an aborted stream.
    always_ff @(posedge clk50) begin
        if (w_wr_ok) begin
            r_mem[f_bank(wr_row)][f_lrow(wr_row)][c_CW'(wr_col)] <= wr_data;
        end
    end

    // Asynchronous read of the pixel about to be loaded; a same-edge write lands
    // after this sample, which gives read-before-write ordering.
    assign w_rd_data = r_mem[f_bank(w_row_nxt)][f_lrow(w_row_nxt)][c_CW'(w_col_nxt)];

    always_comb begin
        w_state_nxt     = r_state;
        w_valid_nxt     = r_valid;
        w_row_nxt       = r_row;
        w_col_nxt       = r_col;
        w_blank_cnt_nxt = r_blank_cnt;
        w_ld            = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_STREAM;
                    w_row_nxt   = 12'd0;
                    w_col_nxt   = 12'd0;
                    w_valid_nxt = 1'b1;
                    w_ld        = 1'b1;
                end
            end
            S_STREAM: begin
                if (w_xfer) begin
                    if (!w_at_eol) begin
                        w_col_nxt = r_col + 12'd1;
                        w_ld      = 1'b1;
                    end else begin
                        w_col_nxt = 12'd0;
                        w_row_nxt = w_at_eof ? 12'd0 : r_row + 12'd1;
                        if (w_at_eof && (CONTINUOUS == 0)) begin
                            w_state_nxt = S_IDLE;
                            w_valid_nxt = 1'b0;
                        end else if (HBLANK > 0) begin
                            w_state_nxt     = S_BLANK;
                            w_valid_nxt     = 1'b0;
                            w_blank_cnt_nxt = 16'd0;
                        end else begin
                            w_ld = 1'b1;
                        end
                    end
                end
            end
            S_BLANK: begin
                if (r_blank_cnt == c_BLANK_LAST) begin
                    w_state_nxt = S_STREAM;
                    w_valid_nxt = 1'b1;
                    w_ld        = 1'b1;
                end else begin
                    w_blank_cnt_nxt = r_blank_cnt + 16'd1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_valid_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk50) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_valid     <= 1'b0;
            r_row       <= 12'd0;
            r_col       <= 12'd0;
            r_blank_cnt <= 16'd0;
            r_data      <= '0;
            r_wr_err    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_valid     <= w_valid_nxt;
            r_row       <= w_row_nxt;
            r_col       <= w_col_nxt;
            r_blank_cnt <= w_blank_cnt_nxt;
            r_wr_err    <= wr_en && !w_wr_ok;
            if (w_ld) begin
                r_data <= w_rd_data;
            end
        end
    end

    assign busy      = (r_state != S_IDLE);
    assign wr_err    = r_wr_err;
    assign m_valid   = r_valid;
    assign m_data    = r_data;
    assign pixel_row = r_row;
    assign pixel_col = r_col;
    assign m_sof     = r_valid && (r_row == 12'd0) && (r_col == 12'd0);
    assign m_eol     = r_valid && w_at_eol;
    assign m_eof     = r_valid && w_at_eof;

endmodule
`default_nettype wire

// File: tb/tb_pixel_stream_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pixel_stream_buffer
// Purpose  : Scoreboard bench driving three buffer variants (plain, blanking,
//            continuous) from shared stimulus against a raster reference model.
// Revision : 1.0
// ============================================================================
module tb_pixel_stream_buffer;

    localparam int W = 4;
    localparam int H = 3;

    typedef struct packed {
        logic [23:0] d;
        logic [11:0] r;
        logic [11:0] c;
        logic        sof;
        logic        eol;
        logic        eof;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        hold_c;
    logic        wr_en;
    logic [11:0] wr_row;
    logic [11:0] wr_col;
    logic [23:0] wr_data;
    logic        start;
    logic        m_ready;

    logic [2:0]  dut_rst;
    logic [2:0]  v_err, v_busy, v_valid, v_sof, v_eol, v_eof;
    logic [23:0] v_data [3];
    logic [11:0] v_row  [3];
    logic [11:0] v_col  [3];

    assign dut_rst = {rst | hold_c, rst, rst};

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int HB = (g == 1) ? 2 : 0;
        localparam int CT = (g == 2) ? 1 : 0;
        pixel_stream_buffer #(
            .CH_W(8), .NUM_CH(3), .IMG_W(W), .IMG_H(H), .BANK_ROWS(2),
            .HBLANK(HB), .CONTINUOUS(CT)
        ) u_dut (
            .clk50(clk), .rst(dut_rst[g]),
            .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data),
            .wr_err(v_err[g]), .start(start), .busy(v_busy[g]),
            .m_valid(v_valid[g]), .m_ready(m_ready), .m_data(v_data[g]),
            .m_sof(v_sof[g]), .m_eol(v_eol[g]), .m_eof(v_eof[g]),
            .pixel_row(v_row[g]), .pixel_col(v_col[g])
        );
    end

    int n_total = 0;
    int n_bad   = 0;

    // Reference model: frame image plus a per-variant raster position.
    logic [23:0] ref_mem [H][W];
    bit e_busy [3] = '{0, 0, 0};
    bit e_valid[3] = '{0, 0, 0};
    bit e_err  [3] = '{0, 0, 0};
    bit e_zero [3] = '{1, 1, 1};
    int e_row  [3] = '{0, 0, 0};
    int e_col  [3] = '{0, 0, 0};
    int e_blank[3] = '{0, 0, 0};
    beat_t q0[$], q1[$], q2[$];

    function automatic int hb_of(int i);
        return (i == 1) ? 2 : 0;
    endfunction

    function automatic bit ct_of(int i);
        return (i == 2);
    endfunction

    function automatic int qsize(int i);
        case (i)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic beat_t qfront(int i);
        case (i)
            0:       return q0[0];
            1:       return q1[0];
            default: return q2[0];
        endcase
    endfunction

    function automatic void qpop(int i);
        case (i)
            0:       void'(q0.pop_front());
            1:       void'(q1.pop_front());
            default: void'(q2.pop_front());
        endcase
    endfunction

    function automatic void qpush(int i, beat_t b);
        case (i)
            0:       q0.push_back(b);
            1:       q1.push_back(b);
            default: q2.push_back(b);
        endcase
    endfunction

    function automatic void qclear(int i);
        case (i)
            0:       q0.delete();
            1:       q1.delete();
            default: q2.delete();
        endcase
    endfunction

    function automatic void load(int i);
        beat_t b;
        b.d   = ref_mem[e_row[i]][e_col[i]];
        b.r   = 12'(e_row[i]);
        b.c   = 12'(e_col[i]);
        b.sof = (e_row[i] == 0) && (e_col[i] == 0);
        b.eol = (e_col[i] == W - 1);
        b.eof = (e_row[i] == H - 1) && (e_col[i] == W - 1);
        e_valid[i] = 1'b1;
        qpush(i, b);
    endfunction

    task automatic chk(input string nm, input int i, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s dut%0d actual=%h expected=%h at %0t", nm, i, act, exp, $time);
        end
    endtask

    // Monitor + model: compare what the DUTs show now, then advance the model
    // using the inputs that the coming rising edge will sample.
    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                logic [50:0] act;
                act = {v_data[i], v_row[i], v_col[i], v_sof[i], v_eol[i], v_eof[i]};
                chk("valid", i, 64'(v_valid[i]), 64'(e_valid[i]));
                chk("busy", i, 64'(v_busy[i]), 64'(e_busy[i]));
                chk("wr_err", i, 64'(v_err[i]), 64'(e_err[i]));
                if (e_zero[i]) chk("reset_outputs", i, 64'(act), 64'd0);
                if (e_valid[i] && v_valid[i]) begin
                    if (qsize(i) == 0) chk("beat_unexpected", i, 64'(act), 64'd0);
                    else               chk("beat", i, 64'(act), 64'(qfront(i)));
                end

                if (dut_rst[i]) begin
                    e_busy[i] = 0; e_valid[i] = 0; e_err[i] = 0; e_zero[i] = 1;
                    e_blank[i] = 0; e_row[i] = 0; e_col[i] = 0;
                    qclear(i);
                end else begin
                    e_err[i] = wr_en && (wr_row >= 12'(H) || wr_col >= 12'(W));
                    if (!e_busy[i]) begin
                        if (start) begin
                            e_busy[i] = 1; e_zero[i] = 0; e_row[i] = 0; e_col[i] = 0;
                            load(i);
                        end
                    end else if (e_blank[i] > 0) begin
                        e_blank[i]--;
                        if (e_blank[i] == 0) load(i);
                    end else if (m_ready) begin
                        bit was_eol;
                        int idx;
                        if (qsize(i) > 0) qpop(i);
                        was_eol = (e_col[i] == W - 1);
                        idx = e_row[i] * W + e_col[i] + 1;
                        if (idx == W * H) begin
                            idx = 0;
                            if (!ct_of(i)) begin
                                e_busy[i] = 0; e_valid[i] = 0;
                            end
                        end
                        if (e_busy[i]) begin
                            e_row[i] = idx / W;
                            e_col[i] = idx % W;
                            if (was_eol && hb_of(i) > 0) begin
                                e_valid[i] = 0;
                                e_blank[i] = hb_of(i);
                            end else begin
                                load(i);
                            end
                        end
                    end
                end
            end
            if (wr_en && wr_row < 12'(H) && wr_col < 12'(W)) ref_mem[wr_row][wr_col] = wr_data;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((e_busy[0] || e_busy[1]) && n < 300) begin
            step();
            n++;
        end
        n_total++;
        if (n >= 300) begin
            n_bad++;
            $display("FAIL wait_idle timeout busy0=%0d busy1=%0d", e_busy[0], e_busy[1]);
        end
        step();
    endtask

    task automatic wait_pix(input int i, input int r, input int c);
        int n = 0;
        while (!(e_valid[i] && e_row[i] == r && e_col[i] == c) && n < 300) begin
            step();
            n++;
        end
        n_total++;
        if (n >= 300) begin
            n_bad++;
            $display("FAIL wait_pix timeout dut%0d want=(%0d,%0d)", i, r, c);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired total=%0d bad=%0d", n_total, n_bad);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; hold_c = 1'b1; wr_en = 1'b0; wr_row = '0; wr_col = '0;
        wr_data = '0; start = 1'b0; m_ready = 1'b0;
        repeat (3) step();
        rst = 1'b0;

        // Load pattern row*16+col.
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                wr_en = 1'b1; wr_row = 12'(r); wr_col = 12'(c); wr_data = 24'(r * 16 + c);
                step();
            end
        end
        wr_en = 1'b0;

        // Straight frame with m_ready held high.
        m_ready = 1'b1;
        pulse_start();
        wait_idle();

        // Out-of-range writes, then a frame that must be unchanged.
        wr_en = 1'b1; wr_row = 12'd3; wr_col = 12'd0; wr_data = 24'hFFFFFF;
        step();
        wr_row = 12'd0; wr_col = 12'd4;
        step();
        wr_en = 1'b0;
        step();
        pulse_start();
        wait_idle();

        // Back-pressure stall on pixel (1,2).
        pulse_start();
        wait_pix(0, 1, 2);
        m_ready = 1'b0;
        step();
        step();
        m_ready = 1'b1;
        wait_idle();

        // Write to the pixel being loaded on the same edge.
        pulse_start();
        wait_pix(0, 0, 1);
        wr_en = 1'b1; wr_row = 12'd0; wr_col = 12'd2; wr_data = 24'hABCDEF;
        step();
        wr_en = 1'b0;
        wait_idle();

        // Reset mid-frame, then restart.
        pulse_start();
        wait_pix(0, 2, 1);
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
        pulse_start();
        wait_idle();

        // Continuous variant: wrap straight from eof back to (0,0).
        hold_c = 1'b0;
        step();
        pulse_start();
        repeat (30) step();

        // Randomised traffic across all variants.
        for (int k = 0; k < 400; k++) begin
            m_ready = ($urandom_range(0, 3) != 0);
            wr_en   = ($urandom_range(0, 3) == 0);
            wr_row  = 12'($urandom_range(0, 3));
            wr_col  = 12'($urandom_range(0, 4));
            wr_data = 24'($urandom);
            start   = ($urandom_range(0, 15) == 0);
            rst     = ($urandom_range(0, 99) == 0);
            step();
        end
        rst = 1'b0; start = 1'b0; wr_en = 1'b0; m_ready = 1'b1;
        hold_c = 1'b1;
        wait_idle();
        pulse_start();
        wait_idle();
        repeat (3) step();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pixel_stream_buffer.md
PIXEL_STREAM_BUFFER -- requirements
Module: pixel_stream_buffer

Interface
REQ-001 SHALL have parameter CH_W, default 32, meaning bits per channel.
REQ-002 SHALL have parameter NUM_CH, default 3, meaning channels per pixel (L, A, B order).
REQ-003 SHALL have parameter IMG_W, default 1448, meaning pixels per line.
REQ-004 SHALL have parameter IMG_H, default 1072, meaning lines per frame.
REQ-005 SHALL have parameter BANK_ROWS, default 67, meaning lines per memory bank.
REQ-006 SHALL have parameter HBLANK, default 0, meaning idle cycles inserted after each line.
REQ-007 SHALL have parameter CONTINUOUS, default 0, meaning 1 = restart the frame automatically, 0 = single frame.
REQ-008 SHALL use one clock and a synchronous, active-high reset, with the ports listed below.
REQ-009 SHALL have port clk50  in  1  sole clock, rising edge.
REQ-010 SHALL have port rst  in  1  synchronous active-high reset.
REQ-011 SHALL have port wr_en  in  1  pixel write strobe.
REQ-012 SHALL have port wr_row  in  12  write line index.
REQ-013 SHALL have port wr_col  in  12  write pixel index.
REQ-014 SHALL have port wr_data  in  NUM_CH*CH_W  pixel; channel 0 occupies the MSBs.
REQ-015 SHALL have port wr_err  out  1  one-cycle pulse on an out-of-range write.
REQ-016 SHALL have port start  in  1  frame start request.
REQ-017 SHALL have port busy  out  1  high in any state other than IDLE.
REQ-018 SHALL have port m_valid  out  1  output pixel valid.
REQ-019 SHALL have port m_ready  in  1  downstream accept.
REQ-020 SHALL have port m_data  out  NUM_CH*CH_W  output pixel; channel 0 occupies the MSBs.
REQ-021 SHALL have ports m_sof / m_eol / m_eof  out  1 each  start-of-frame / end-of-line / end-of-frame flags, qualified by m_valid.
REQ-022 SHALL have ports pixel_row / pixel_col  out  12 each  coordinates of the pixel currently on m_data.

Function
REQ-023 Storage SHALL be NUM_BANKS = ceil(IMG_H/BANK_ROWS) banks of BANK_ROWS x IMG_W words, indexed as bank = row / BANK_ROWS and local row = row mod BANK_ROWS.
REQ-024 A write SHALL occur when wr_en=1, wr_row<IMG_H and wr_col<IMG_W; otherwise no storage changes and wr_err=1 for the next cycle only.
REQ-025 The state machine SHALL have the states IDLE, STREAM and BLANK.
REQ-026 IDLE->STREAM: on start=1, the next cycle SHALL present m_valid=1 with pixel (0,0) and m_sof=1; start SHALL be ignored when busy=1.
REQ-027 Transfer SHALL occur when m_valid & m_ready; without a transfer, m_data, flags and coordinates SHALL hold stable.
REQ-028 On a transfer, the register SHALL load the next pixel on the same edge, giving one pixel per cycle while m_ready=1.
REQ-029 Flags: m_sof=1 at (0,0); m_eol=1 at col IMG_W-1; m_eof=1 at (IMG_H-1, IMG_W-1).
REQ-030 On an eol transfer with HBLANK>0, the block SHALL enter BLANK for exactly HBLANK cycles with m_valid=0, then STREAM at (row+1, 0).
REQ-031 On an eof transfer, the block SHALL wrap to (0,0) when CONTINUOUS=1 (passing through BLANK if HBLANK>0); otherwise it SHALL go to IDLE with m_valid=0 the next cycle.
REQ-032 When a write and an output-register load hit the same address in the same cycle, the output SHALL return the old data (read-before-write).
REQ-033 Writes SHALL be accepted in every state.
REQ-034 Coordinate counters SHALL be 12 bits wide and SHALL never exceed IMG_W-1 / IMG_H-1.

Reset
REQ-035 While rst=1 the block SHALL go to IDLE and SHALL drive m_valid, m_data, m_sof, m_eol, m_eof, pixel_row, pixel_col, busy and wr_err to 0.
REQ-036 Reset SHALL NOT clear memory contents.
REQ-037 Reset asserted mid-frame SHALL abort the frame, and the next start SHALL begin at (0,0).

Verification (IMG_W=4, IMG_H=3, BANK_ROWS=2, NUM_CH=3, CH_W=8)
REQ-038 Bench SHALL cover: load pixel value = row*16+col, m_ready=1, start -> 12 consecutive valid beats 0x000000..0x000023 (packed row*16+col, zero upper channels), m_sof on beat 0, m_eol on beats 3/7/11, m_eof on beat 11, then m_valid=0.
REQ-039 Bench SHALL cover: HBLANK=2 -> exactly 2 invalid cycles after beats 3 and 7, none after beat 11 when CONTINUOUS=0.
REQ-040 Bench SHALL cover: m_ready toggled 1,0,0,1 at pixel (1,2) -> m_data and pixel_col=2 held through the stall, and no beat dropped or duplicated.
REQ-041 Bench SHALL cover: write to (3,0), then write to (0,4) -> wr_err pulses 1 cycle each and the streamed frame is unchanged.
REQ-042 Bench SHALL cover: rst=1 at pixel (2,1) then start -> busy=0 and outputs 0 during reset, the restart begins at (0,0) with m_sof=1, and the data equals the pre-reset contents.
REQ-043 Bench SHALL cover: CONTINUOUS=1 -> beat 12 equals pixel (0,0) with m_sof=1 directly after the m_eof beat.
